mplx_monitor: RTL
=================

Name: mplx_monitor

Overview:
- Receive-side checker and display decoder for the 3-bit `result` stream produced by the dice/traffic-light multiplexer.
- Samples `sel`, `button` and `result` every clock and checks that each value is legal and follows the correct sequence for the selected mode.
- Decodes dice values into a 7-LED pip pattern, flags protocol errors, and counts completed traffic-light cycles.
- Sits beside the multiplexer in top-level benches and on-board self-check builds.

Parameters:
- CNT_W, 8, width of `err_count` and `tl_cycles`; both saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous reset, active-low
- sel  input  1  mode: 0 = dice, 1 = traffic lights (same meaning as the multiplexer's `sel`)
- button  input  1  dice roll enable, as driven to the multiplexer
- result  input  3  multiplexer output; dice = binary 1..6; lights = {red, amber, green}
- pips  output  7  dice pip LEDs: [0] centre, [1] top-left, [2] top-right, [3] mid-left, [4] mid-right, [5] bottom-left, [6] bottom-right
- err  output  1  one-cycle pulse when a sample fails a check
- err_sticky  output  1  set by any error; cleared only by reset
- err_count  output  CNT_W  number of error samples, saturating
- tl_cycles  output  CNT_W  number of completed red-to-red light cycles, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - Internal registers r_q=000, b_q=0, sel_q=0; state = SYNC.
- Registered prior samples: at every rising edge, r_q<=result, b_q<=button, sel_q<=sel. This includes error and SYNC edges, so checking resynchronises to the observed value and errors do not cascade.
- Legal codes:
  - Dice: 001..110.
  - Lights: 100 (R), 110 (RA), 001 (G), 010 (A).
- Expected next value:
  - Dice: if b_q=1, next(r_q) where 1->2->3->4->5->6->1; if b_q=0, r_q.
  - Lights: R->RA->G->A->R, advancing every cycle regardless of `button`.
- State machine: SYNC, TRACK.
  - SYNC: the sample is checked for legality only; the state then goes to TRACK.
  - TRACK, sel==sel_q: error if `result` is illegal or differs from the expected value.
  - TRACK, sel!=sel_q (mode change): this sample is treated as SYNC for the new mode (legality only). The state stays TRACK and normal checks resume next edge.
- `err`: registered; high for the cycle following the offending sampling edge, low otherwise. Back-to-back errors hold `err` high on consecutive cycles.
- `err_count`: increments by 1 on each error edge; holds at all-ones.
- `tl_cycles`: increments on a legal TRACK-state A->R transition in lights mode (r_q=010, result=100, sel=sel_q=1); saturates. Never counts on SYNC or mode-change samples.
- `pips`: registered from the current sample.
  - When sel=0 and `result` is legal: 1=0000001, 2=1000010, 3=1000011, 4=1100110, 5=1100111, 6=1111110.
  - Otherwise (lights mode, or illegal dice code): 0000000.
- Latency: one clock from sampled input to every output.
- Reset mid-operation: outputs clear immediately without waiting for an edge; the first edge after release is a SYNC sample.
- Counters never wrap.

Test Plan:
- Reset: hold rst=0, drive random inputs -> all outputs 0 throughout; release and drive result=011, sel=0 -> no err, pips=1000011 next cycle.
- Dice roll: sel=0, button=1, drive 1,2,3,4,5,6,1 on consecutive cycles -> err never set, pips follows table; then button=0 and result holds at 1 -> no err; then drive 3 -> err pulse 1 cycle, err_count=1, err_sticky=1.
- Lights: sel=1, drive R,RA,G,A,R,RA,G,A,R -> no err, tl_cycles=2, pips=0; insert 111 -> err pulse, err_count increments; the next correct successor of 111 is still flagged, then checks resync.
- Mode change: running dice, switch sel 0->1 with result=001 -> no err (legality only); switch with result=111 -> err.
- Saturation: CNT_W=2, inject 5 consecutive errors -> err high 5 cycles, err_count=3 and holding.
- Async reset mid-run: pull rst low between edges while err_count=2 -> all outputs 0 before the next edge; after release, the first sample is SYNC.

Source files
------------

// File: rtl/mplx_monitor.sv
// mplx_monitor
//   Receive-side checker and pip decoder for the 3-bit result stream of the
//   dice / traffic-light multiplexer. Every edge it samples sel, button and
//   result, checks legality and sequencing against the previous sample, and
//   drives registered status outputs one clock later.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   sel        mode: 0 = dice, 1 = traffic lights
//   button     dice roll enable as seen by the multiplexer
//   result     multiplexer output (dice 1..6, lights {red, amber, green})
//   pips       dice pip LEDs [0] centre, [1] TL, [2] TR, [3] ML, [4] MR, [5] BL, [6] BR
//   err        one-cycle pulse per failing sample
//   err_sticky set by any error, cleared only by reset
//   err_count  saturating count of failing samples
//   tl_cycles  saturating count of completed red-to-red light cycles
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_SYNC  | no trusted prior sample; current sample checked for legality only
// S_TRACK | prior sample valid; full legality + sequence check
module mplx_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             button,
  input  logic [2:0]       result,
  output logic [6:0]       pips,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] tl_cycles
);

  typedef enum logic {S_SYNC, S_TRACK} state_t;

  localparam logic [2:0] L_R  = 3'b100;
  localparam logic [2:0] L_RA = 3'b110;
  localparam logic [2:0] L_G  = 3'b001;
  localparam logic [2:0] L_A  = 3'b010;

  state_t           state_q, state_d;
  logic [2:0]       r_q, r_d;
  logic             b_q, b_d;
  logic             sel_q, sel_d;
  logic [6:0]       pips_q, pips_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tl_q, tl_d;

  logic       dice_legal, lights_legal, legal;
  logic       sync_sample, tl_hit;
  logic [2:0] next_dice, next_light, expected;

  always_comb begin
    dice_legal = (result >= 3'd1) && (result <= 3'd6);

    lights_legal = 1'b0;
    case (result)
      L_R, L_RA, L_G, L_A: lights_legal = 1'b1;
      default:             lights_legal = 1'b0;
    endcase

    legal = sel ? lights_legal : dice_legal;

    // Successors of an illegal prior value map to 000, which is never legal,
    // so the sample after a bad code is still flagged.
    next_dice = 3'b000;
    case (r_q)
      3'd1:    next_dice = 3'd2;
      3'd2:    next_dice = 3'd3;
      3'd3:    next_dice = 3'd4;
      3'd4:    next_dice = 3'd5;
      3'd5:    next_dice = 3'd6;
      3'd6:    next_dice = 3'd1;
      default: next_dice = 3'b000;
    endcase

    next_light = 3'b000;
    case (r_q)
      L_R:     next_light = L_RA;
      L_RA:    next_light = L_G;
      L_G:     next_light = L_A;
      L_A:     next_light = L_R;
      default: next_light = 3'b000;
    endcase

    if (sel) expected = next_light;
    else     expected = b_q ? next_dice : r_q;

    // A mode change restarts checking for the new mode just like SYNC.
    sync_sample = (state_q == S_SYNC) || (sel != sel_q);

    err_d  = sync_sample ? !legal : (!legal || (result != expected));
    tl_hit = !sync_sample && sel && (r_q == L_A) && (result == L_R);

    pips_d = 7'b0000000;
    if (!sel) begin
      case (result)
        3'd1:    pips_d = 7'b0000001;
        3'd2:    pips_d = 7'b1000010;
        3'd3:    pips_d = 7'b1000011;
        3'd4:    pips_d = 7'b1100110;
        3'd5:    pips_d = 7'b1100111;
        3'd6:    pips_d = 7'b1111110;
        default: pips_d = 7'b0000000;
      endcase
    end

    sticky_d = sticky_q | err_d;
    cnt_d    = (err_d && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    tl_d     = (tl_hit && (tl_q != '1)) ? tl_q + CNT_W'(1) : tl_q;

    // Prior samples always follow the input, so checking resyncs after errors.
    r_d     = result;
    b_d     = button;
    sel_d   = sel;
    state_d = S_TRACK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_SYNC;
      r_q      <= 3'b000;
      b_q      <= 1'b0;
      sel_q    <= 1'b0;
      pips_q   <= 7'b0000000;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      tl_q     <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      pips_q   <= pips_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      tl_q     <= tl_d;
    end
  end

  assign pips       = pips_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;
  assign tl_cycles  = tl_q;

endmodule
